// File: rtl/pwm_pulse_meas_if.sv
// Pin-under-test and result bus for pwm_pulse_meas; the monitor drives results, the pin comes from outside.
// Latency/backpressure: none at this level; results are register outputs of the monitor.
interface pwm_pulse_meas_if #(
  parameter int CNT_W = 32
);
  logic             pwm_in;
  logic             meas_valid;
  logic [CNT_W-1:0] high_cycles;
  logic [CNT_W-1:0] low_cycles;
  logic [CNT_W:0]   period_cycles;
  logic             meas_sat;
  logic             stuck;
  logic             stuck_level;

  modport master (
    input  pwm_in,
    output meas_valid, high_cycles, low_cycles, period_cycles, meas_sat, stuck, stuck_level
  );

  modport slave (
    output pwm_in,
    input  meas_valid, high_cycles, low_cycles, period_cycles, meas_sat, stuck, stuck_level
  );
endinterface

// File: rtl/pwm_pulse_meas.sv
// PWM phase monitor: one high/low/period result per full period, stuck-pin flag; PWM_MEAS_GLITCH_FILTER_EN adds a level filter.
// Strobe 3 clocks after the edge that samples a rise (+GLITCH_CYCLES when filtered); no backpressure, results hold until next strobe.
module pwm_pulse_meas #(
  parameter int CNT_W          = 32,
  parameter int TIMEOUT_CYCLES = 270000000,
  parameter int GLITCH_CYCLES  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  pwm_pulse_meas_if.master bus
);
  localparam int               TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [TO_W-1:0]  TO_VAL  = TO_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {WAIT_RISE, MEAS_HIGH, MEAS_LOW} state_t;

  logic sync_q1, sync_q2, lvl, prev_q, rise_q, fall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= bus.pwm_in;
      sync_q2 <= sync_q1;
    end
  end

`ifdef PWM_MEAS_GLITCH_FILTER_EN
  localparam int GW = $clog2(GLITCH_CYCLES + 1);
  logic          filt_q;
  logic [GW-1:0] gcnt_q;

  // A new level is taken only after GLITCH_CYCLES identical samples in a row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q <= 1'b0;
      gcnt_q <= '0;
    end else if (sync_q2 == filt_q) begin
      gcnt_q <= '0;
    end else if (gcnt_q == GW'(GLITCH_CYCLES - 1)) begin
      filt_q <= sync_q2;
      gcnt_q <= '0;
    end else begin
      gcnt_q <= gcnt_q + 1'b1;
    end
  end

  assign lvl = filt_q;
`else
  assign lvl = sync_q2;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      prev_q <= lvl;
      rise_q <= lvl & ~prev_q;
      fall_q <= ~lvl & prev_q;
    end
  end

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, hi_q, hi_d, high_q, high_d, low_q, low_d, cnt_inc;
  logic [CNT_W:0]   per_q, per_d;
  logic             ph_sat_q, ph_sat_d, hi_sat_q, hi_sat_d, sat_q, sat_d, vld_q, vld_d;
  logic             stuck_q, stuck_d, stuck_lvl_q, stuck_lvl_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic             edge_seen, timeout;

  assign edge_seen = rise_q | fall_q;
  // The timeout counter restarts on every edge, so an edge always beats a timeout.
  assign timeout   = (TIMEOUT_CYCLES != 0) && (to_q == TO_VAL) && !edge_seen;
  assign cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_inc;
    ph_sat_d    = ph_sat_q | (cnt_q == CNT_MAX);
    hi_d        = hi_q;
    hi_sat_d    = hi_sat_q;
    high_d      = high_q;
    low_d       = low_q;
    per_d       = per_q;
    sat_d       = sat_q;
    vld_d       = 1'b0;
    stuck_d     = stuck_q & ~edge_seen;
    stuck_lvl_d = stuck_lvl_q;
    if (edge_seen)
      to_d = TO_W'(1);
    else if (to_q != TO_VAL)
      to_d = to_q + 1'b1;
    else
      to_d = to_q;

    unique case (state_q)
      WAIT_RISE: begin
        cnt_d    = cnt_q;
        ph_sat_d = 1'b0;
        if (rise_q) begin
          cnt_d   = CNT_W'(1);
          state_d = MEAS_HIGH;
        end
      end
      MEAS_HIGH: begin
        if (fall_q) begin
          hi_d     = cnt_q;
          hi_sat_d = ph_sat_q;
          cnt_d    = CNT_W'(1);
          ph_sat_d = 1'b0;
          state_d  = MEAS_LOW;
        end
      end
      MEAS_LOW: begin
        if (rise_q) begin
          high_d   = hi_q;
          low_d    = cnt_q;
          per_d    = {1'b0, hi_q} + {1'b0, cnt_q};
          sat_d    = hi_sat_q | ph_sat_q;
          vld_d    = 1'b1;
          cnt_d    = CNT_W'(1);
          ph_sat_d = 1'b0;
          state_d  = MEAS_HIGH;
        end
      end
      default: state_d = WAIT_RISE;
    endcase

    // A timed-out phase is dropped and measurement re-arms on the next rise.
    if (timeout) begin
      stuck_d     = 1'b1;
      stuck_lvl_d = lvl;
      state_d     = WAIT_RISE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= WAIT_RISE;
      cnt_q       <= '0;
      ph_sat_q    <= 1'b0;
      hi_q        <= '0;
      hi_sat_q    <= 1'b0;
      high_q      <= '0;
      low_q       <= '0;
      per_q       <= '0;
      sat_q       <= 1'b0;
      vld_q       <= 1'b0;
      stuck_q     <= 1'b0;
      stuck_lvl_q <= 1'b0;
      to_q        <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ph_sat_q    <= ph_sat_d;
      hi_q        <= hi_d;
      hi_sat_q    <= hi_sat_d;
      high_q      <= high_d;
      low_q       <= low_d;
      per_q       <= per_d;
      sat_q       <= sat_d;
      vld_q       <= vld_d;
      stuck_q     <= stuck_d;
      stuck_lvl_q <= stuck_lvl_d;
      to_q        <= to_d;
    end
  end

  assign bus.meas_valid    = vld_q;
  assign bus.high_cycles   = high_q;
  assign bus.low_cycles    = low_q;
  assign bus.period_cycles = per_q;
  assign bus.meas_sat      = sat_q;
  assign bus.stuck         = stuck_q;
  assign bus.stuck_level   = stuck_lvl_q;
endmodule

// File: tb/tb_pwm_pulse_meas.sv
// Directed bench for pwm_pulse_meas: instance A (CNT_W=16, timeout 100) and instance B (CNT_W=4, no timeout).
// Expected results are queued when the rise that closes a period is driven and popped when the strobe appears.
`timescale 1ns/1ps
module tb_pwm_pulse_meas;
  typedef struct packed {
    logic [15:0] h;
    logic [15:0] l;
    logic [16:0] p;
    logic        sat;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pwm_pulse_meas_if #(.CNT_W(16)) bus_a ();
  pwm_pulse_meas_if #(.CNT_W(4))  bus_b ();

  pwm_pulse_meas #(.CNT_W(16), .TIMEOUT_CYCLES(100), .GLITCH_CYCLES(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a));
  pwm_pulse_meas #(.CNT_W(4), .TIMEOUT_CYCLES(0), .GLITCH_CYCLES(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b));

  exp_t qa[$];
  exp_t qb[$];
  int   checks = 0, errors = 0, strobes_a = 0, strobes_b = 0;
  int   strobe_at = -1, hi_at = -1, prev_h = 0, prev_l = 0;
  bit   armed = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push_a(input int h, input int l);
    exp_t e;
    e.h = 16'(h); e.l = 16'(l); e.p = 17'(h + l); e.sat = 1'b0;
    qa.push_back(e);
  endtask

  task automatic push_b(input int h, input int l, input logic s);
    exp_t e;
    e.h = 16'(h); e.l = 16'(l); e.p = 17'(h + l); e.sat = s;
    qb.push_back(e);
  endtask

  task automatic sample(input int idx);
    exp_t e;
    if (bus_a.meas_valid) begin
      strobes_a++;
      strobe_at = idx;
      chk("a_strobe_expected", 32'(qa.size() != 0), 32'd1);
      if (qa.size() != 0) begin
        e = qa.pop_front();
        chk("a_high_cycles", 32'(bus_a.high_cycles), 32'(e.h));
        chk("a_low_cycles", 32'(bus_a.low_cycles), 32'(e.l));
        chk("a_period_cycles", 32'(bus_a.period_cycles), 32'(e.p));
        chk("a_meas_sat", 32'(bus_a.meas_sat), 32'(e.sat));
      end
    end
    if (bus_b.meas_valid) begin
      strobes_b++;
      chk("b_strobe_expected", 32'(qb.size() != 0), 32'd1);
      if (qb.size() != 0) begin
        e = qb.pop_front();
        chk("b_high_cycles", 32'(bus_b.high_cycles), 32'(e.h));
        chk("b_low_cycles", 32'(bus_b.low_cycles), 32'(e.l));
        chk("b_period_cycles", 32'(bus_b.period_cycles), 32'(e.p));
        chk("b_meas_sat", 32'(bus_b.meas_sat), 32'(e.sat));
      end
    end
  endtask

  // Drive one instance's pin for n cycles; inputs change 1 ns after the rising edge.
  task automatic drive(input bit to_b, input logic lvl, input int n);
    strobe_at = -1;
    for (int i = 1; i <= n; i++) begin
      if (to_b) bus_b.pwm_in = lvl;
      else      bus_a.pwm_in = lvl;
      @(posedge clk);
      #1;
      sample(i);
    end
  endtask

  task automatic per_a(input int h, input int l);
    if (armed) push_a(prev_h, prev_l);
    drive(1'b0, 1'b1, h);
    hi_at = strobe_at;
    drive(1'b0, 1'b0, l);
    prev_h = h;
    prev_l = l;
    armed  = 1'b1;
  endtask

  initial begin
    bus_a.pwm_in = 1'b0;
    bus_b.pwm_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_meas_valid", 32'(bus_a.meas_valid), 32'd0);
    chk("rst_high", 32'(bus_a.high_cycles), 32'd0);
    chk("rst_low", 32'(bus_a.low_cycles), 32'd0);
    chk("rst_period", 32'(bus_a.period_cycles), 32'd0);
    chk("rst_sat", 32'(bus_a.meas_sat), 32'd0);
    chk("rst_stuck", 32'(bus_a.stuck), 32'd0);
    chk("rst_stuck_level", 32'(bus_a.stuck_level), 32'd0);
    rst_n = 1'b1;

    // Saturation on the narrow, timeout-free instance
    drive(1'b1, 1'b0, 2);
    drive(1'b1, 1'b1, 20);
    drive(1'b1, 1'b0, 3);
    push_b(15, 3, 1'b1);
    drive(1'b1, 1'b1, 5);
    drive(1'b1, 1'b0, 5);
    push_b(5, 5, 1'b0);
    drive(1'b1, 1'b1, 5);
    drive(1'b1, 1'b0, 4);
    chk("b_strobe_count", 32'(strobes_b), 32'd2);
    chk("b_queue_drained", 32'(qb.size()), 32'd0);

    // Repeating 10/5; first rise only arms
    chk("a_idle_stuck", 32'(bus_a.stuck), 32'd0);
    drive(1'b0, 1'b0, 3);
    per_a(10, 5);
    chk("a_first_rise_no_strobe", 32'(strobes_a), 32'd0);
    per_a(10, 5);
    chk("a_strobe_latency", 32'(hi_at), 32'd4);
    chk("a_result_hold", 32'(bus_a.high_cycles), 32'd10);
    per_a(10, 5);
    per_a(10, 5);

    // Scaled upstream pattern, looped twice
    for (int k = 0; k < 2; k++) begin
      per_a(10, 10);
      per_a(20, 10);
      per_a(30, 10);
    end

    // Stuck high, recovery, re-arm
    push_a(prev_h, prev_l);
    drive(1'b0, 1'b1, 98);
    chk("a_stuck_not_yet", 32'(bus_a.stuck), 32'd0);
    drive(1'b0, 1'b1, 7);
    chk("a_stuck_high", 32'(bus_a.stuck), 32'd1);
    chk("a_stuck_level_high", 32'(bus_a.stuck_level), 32'd1);
    armed = 1'b0;
    drive(1'b0, 1'b0, 6);
    chk("a_stuck_cleared", 32'(bus_a.stuck), 32'd0);
    drive(1'b0, 1'b0, 1);
    per_a(8, 9);
    per_a(6, 6);
    chk("a_queue_before_reset", 32'(qa.size()), 32'd0);
    chk("a_hold_before_reset", 32'(bus_a.high_cycles), 32'd8);

    // Asynchronous reset in MEAS_LOW
    #2 rst_n = 1'b0;
    #1;
    chk("a_async_rst_high", 32'(bus_a.high_cycles), 32'd0);
    chk("a_async_rst_low", 32'(bus_a.low_cycles), 32'd0);
    chk("a_async_rst_period", 32'(bus_a.period_cycles), 32'd0);
    drive(1'b0, 1'b0, 2);
    rst_n = 1'b1;
    armed = 1'b0;
    per_a(6, 6);
    per_a(6, 6);
    per_a(6, 6);

    // High 30 split by a 2-cycle low glitch, then low 10
`ifdef PWM_MEAS_GLITCH_FILTER_EN
    push_a(prev_h, prev_l);
    drive(1'b0, 1'b1, 14);
    drive(1'b0, 1'b0, 2);
    drive(1'b0, 1'b1, 14);
    drive(1'b0, 1'b0, 10);
    prev_h = 30;
    prev_l = 10;
`else
    per_a(14, 2);
    per_a(14, 10);
`endif
    per_a(10, 10);

    // Stuck low while measuring the low phase
    drive(1'b0, 1'b0, 85);
    chk("a_stuck_low_not_yet", 32'(bus_a.stuck), 32'd0);
    drive(1'b0, 1'b0, 10);
    chk("a_stuck_low", 32'(bus_a.stuck), 32'd1);
    chk("a_stuck_level_low", 32'(bus_a.stuck_level), 32'd0);

    chk("a_queue_drained", 32'(qa.size()), 32'd0);
`ifdef PWM_MEAS_GLITCH_FILTER_EN
    chk("a_strobe_count", 32'(strobes_a), 32'd15);
`else
    chk("a_strobe_count", 32'(strobes_a), 32'd16);
`endif
    chk("b_no_late_strobe", 32'(strobes_b), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
